// File: rtl/time_counter.sv
// time_counter
//   Time-of-day source for the character-LCD path. It divides clk down to a
//   1 Hz tick and keeps HH:MM:SS as six BCD digits, with hour/minute set
//   buttons and a held refresh request toward the LCD driver.
//
// Ports
//   clk          system clock, shared with the LCD driver
//   reset        asynchronous reset, active low
//   run          1 = time advances, 0 = prescaler and digits frozen
//   inc_hour     set-hour button level; acts on its rising edge only
//   inc_min      set-minute button level; acts on its rising edge only
//   refresh_ack  one-cycle pulse from the LCD driver: time field redrawn
//   digits       BCD {H10,H1,M10,M1,S10,S1}, H10 in [23:20]
//   sec_pulse    one-cycle pulse on each seconds advance
//   refresh_req  high while a digit change has not been acknowledged
module time_counter #(
   parameter int CLOCK_RATE = 1000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        run,
   input  logic        inc_hour,
   input  logic        inc_min,
   input  logic        refresh_ack,
   output logic [23:0] digits,
   output logic        sec_pulse,
   output logic        refresh_req
);

   localparam int             PW         = $clog2(CLOCK_RATE);
   localparam logic [PW-1:0]  PRESC_LAST = PW'(CLOCK_RATE - 1);

   logic [PW-1:0] r_presc;
   logic          r_prev_hour;
   logic          r_prev_min;
   logic [23:0]   r_digits;
   logic          r_sec_pulse;
   logic          r_refresh_req;

   logic          w_tick;
   logic          w_edge_hour;
   logic          w_edge_min;
   logic          w_adv;
   logic          w_change;
   logic          w_sec_carry;
   logic          w_min_carry;
   logic [3:0]    w_h10, w_h1, w_m10, w_m1, w_s10, w_s1;

   assign w_tick      = run && (r_presc == PRESC_LAST);
   assign w_edge_hour = inc_hour & ~r_prev_hour;
   assign w_edge_min  = inc_min  & ~r_prev_min;
   // A button edge steals the tick that lands in the same cycle.
   assign w_adv       = w_tick & ~w_edge_hour & ~w_edge_min;
   assign w_change    = w_adv | w_edge_hour | w_edge_min;

   always_comb begin
      {w_h10, w_h1, w_m10, w_m1, w_s10, w_s1} = r_digits;
      w_sec_carry = 1'b0;
      w_min_carry = 1'b0;

      if (w_edge_min) begin
         w_s10 = 4'd0;
         w_s1  = 4'd0;
      end else if (w_adv) begin
         if (w_s1 == 4'd9) begin
            w_s1 = 4'd0;
            if (w_s10 == 4'd5) begin
               w_s10       = 4'd0;
               w_sec_carry = 1'b1;
            end else begin
               w_s10 = w_s10 + 4'd1;
            end
         end else begin
            w_s1 = w_s1 + 4'd1;
         end
      end

      // The set button wraps minutes 59->00 without touching hours; only a
      // seconds carry may propagate onward (the two never coincide).
      if (w_edge_min || w_sec_carry) begin
         if (w_m1 == 4'd9) begin
            w_m1 = 4'd0;
            if (w_m10 == 4'd5) begin
               w_m10       = 4'd0;
               w_min_carry = w_sec_carry;
            end else begin
               w_m10 = w_m10 + 4'd1;
            end
         end else begin
            w_m1 = w_m1 + 4'd1;
         end
      end

      if (w_edge_hour || w_min_carry) begin
         if (w_h10 == 4'd2 && w_h1 == 4'd3) begin
            w_h10 = 4'd0;
            w_h1  = 4'd0;
         end else if (w_h1 == 4'd9) begin
            w_h1  = 4'd0;
            w_h10 = w_h10 + 4'd1;
         end else begin
            w_h1 = w_h1 + 4'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_presc       <= '0;
         r_prev_hour   <= 1'b0;
         r_prev_min    <= 1'b0;
         r_digits      <= '0;
         r_sec_pulse   <= 1'b0;
         r_refresh_req <= 1'b1;
      end else begin
         r_prev_hour <= inc_hour;
         r_prev_min  <= inc_min;

         if (w_edge_min) begin
            r_presc <= '0;
         end else if (run) begin
            r_presc <= w_tick ? '0 : r_presc + 1'b1;
         end

         r_digits    <= {w_h10, w_h1, w_m10, w_m1, w_s10, w_s1};
         r_sec_pulse <= w_adv;

         // A new change outranks an ack arriving in the same cycle.
         if (w_change) begin
            r_refresh_req <= 1'b1;
         end else if (refresh_ack) begin
            r_refresh_req <= 1'b0;
         end
      end
   end

   assign digits      = r_digits;
   assign sec_pulse   = r_sec_pulse;
   assign refresh_req = r_refresh_req;

endmodule

// File: tb/tb_time_counter.sv
// tb_time_counter
//   Bench for time_counter with CLOCK_RATE=4. A decimal reference model is
//   stepped alongside the DUT; each cycle's expectation is queued when the
//   inputs are driven and popped after the clock edge. A vector table and a
//   few hand-written sequences add absolute checks at points of interest.
module tb_time_counter;

   localparam int CR = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        run;
   logic        inc_hour;
   logic        inc_min;
   logic        refresh_ack;
   logic [23:0] digits;
   logic        sec_pulse;
   logic        refresh_req;

   time_counter #(.CLOCK_RATE(CR)) dut (
      .clk         (clk),
      .reset       (reset),
      .run         (run),
      .inc_hour    (inc_hour),
      .inc_min     (inc_min),
      .refresh_ack (refresh_ack),
      .digits      (digits),
      .sec_pulse   (sec_pulse),
      .refresh_req (refresh_req)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [23:0] d;
      logic        p;
      logic        r;
   } exp_t;

   typedef struct {
      string       name;
      logic        run;
      logic        ih;
      logic        im;
      logic        ak;
      int          n;
      logic [23:0] d;
      logic        p;
      logic        r;
   } vec_t;

   exp_t q[$];
   vec_t vt[8];
   int   tot = 0;
   int   bad = 0;
   int   cyc = 0;

   int   mh, mm, ms, mp;
   bit   mprev_h, mprev_m, mreq;

   function automatic logic [23:0] bcd(input int h, input int m, input int s);
      return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
   endfunction

   task automatic model_reset();
      mh = 0; mm = 0; ms = 0; mp = 0;
      mprev_h = 0; mprev_m = 0; mreq = 1;
      q.delete();
   endtask

   task automatic step(input logic a_run, input logic a_ih, input logic a_im, input logic a_ak);
      exp_t e;
      bit   tick, eh, em, adv;
      run = a_run; inc_hour = a_ih; inc_min = a_im; refresh_ack = a_ak;
      tick = a_run && (mp == CR - 1);
      eh   = a_ih && !mprev_h;
      em   = a_im && !mprev_m;
      adv  = tick && !eh && !em;
      if (em) mp = 0;
      else if (a_run) mp = tick ? 0 : mp + 1;
      if (em) begin
         mm = (mm + 1) % 60;
         ms = 0;
      end
      if (eh) mh = (mh + 1) % 24;
      if (adv) begin
         ms = ms + 1;
         if (ms == 60) begin
            ms = 0;
            mm = mm + 1;
            if (mm == 60) begin
               mm = 0;
               mh = (mh + 1) % 24;
            end
         end
      end
      if (adv || eh || em) mreq = 1;
      else if (a_ak) mreq = 0;
      mprev_h = a_ih;
      mprev_m = a_im;
      e.d = bcd(mh, mm, ms);
      e.p = adv;
      e.r = mreq;
      q.push_back(e);
      @(posedge clk);
      #1;
      cyc++;
      e = q.pop_front();
      tot++;
      if (digits !== e.d || sec_pulse !== e.p || refresh_req !== e.r) begin
         bad++;
         $display("FAIL model cycle %0d: got digits=%h pulse=%b req=%b, expected digits=%h pulse=%b req=%b",
                  cyc, digits, sec_pulse, refresh_req, e.d, e.p, e.r);
      end
   endtask

   task automatic check(input string name, input logic [23:0] d, input logic p, input logic r);
      tot++;
      if (digits !== d || sec_pulse !== p || refresh_req !== r) begin
         bad++;
         $display("FAIL %s: got digits=%h pulse=%b req=%b, expected digits=%h pulse=%b req=%b",
                  name, digits, sec_pulse, refresh_req, d, p, r);
      end
   endtask

   task automatic press(input logic h, input logic m);
      step(1'b0, h, m, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vt[0] = '{"first_tick",   1'b1, 1'b0, 1'b0, 1'b0,  4, 24'h000001, 1'b1, 1'b1};
      vt[1] = '{"tenth_tick",   1'b1, 1'b0, 1'b0, 1'b0, 36, 24'h000010, 1'b1, 1'b1};
      vt[2] = '{"mid_count",    1'b1, 1'b0, 1'b0, 1'b0,  2, 24'h000010, 1'b0, 1'b1};
      vt[3] = '{"run_low_hold", 1'b0, 1'b0, 1'b0, 1'b0, 20, 24'h000010, 1'b0, 1'b1};
      vt[4] = '{"resume_pre",   1'b1, 1'b0, 1'b0, 1'b0,  1, 24'h000010, 1'b0, 1'b1};
      vt[5] = '{"resume_tick",  1'b1, 1'b0, 1'b0, 1'b0,  1, 24'h000011, 1'b1, 1'b1};
      vt[6] = '{"ack_clear",    1'b0, 1'b0, 1'b0, 1'b1,  1, 24'h000011, 1'b0, 1'b0};
      vt[7] = '{"idle_no_req",  1'b0, 1'b0, 1'b0, 1'b0,  3, 24'h000011, 1'b0, 1'b0};

      reset = 1'b0; run = 1'b1; inc_hour = 1'b0; inc_min = 1'b0; refresh_ack = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check("reset_state", 24'h000000, 1'b0, 1'b1);
      reset = 1'b1;

      for (int i = 0; i < 8; i++) begin
         for (int k = 0; k < vt[i].n; k++) step(vt[i].run, vt[i].ih, vt[i].im, vt[i].ak);
         check(vt[i].name, vt[i].d, vt[i].p, vt[i].r);
      end

      // ack arriving together with a tick must leave the request set
      repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b1);
      check("ack_on_tick", 24'h000012, 1'b1, 1'b1);
      step(1'b0, 1'b0, 1'b0, 1'b1);
      check("ack_no_change", 24'h000012, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b1);

      // held hour button: one increment only
      repeat (10) step(1'b0, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0);
      check("hour_held", 24'h010012, 1'b0, 1'b1);

      // asynchronous reset mid-count
      repeat (2) step(1'b1, 1'b0, 1'b0, 1'b0);
      reset = 1'b0;
      #2;
      check("async_reset", 24'h000000, 1'b0, 1'b1);
      model_reset();
      @(posedge clk);
      #1;
      reset = 1'b1;

      // set to 23:59 then run up to the midnight rollover
      repeat (23) press(1'b1, 1'b0);
      repeat (59) press(1'b0, 1'b1);
      check("set_2359", 24'h235900, 1'b0, 1'b1);
      repeat (59 * CR) step(1'b1, 1'b0, 1'b0, 1'b0);
      check("at_235959", 24'h235959, 1'b1, 1'b1);
      repeat (CR) step(1'b1, 1'b0, 1'b0, 1'b0);
      check("midnight", 24'h000000, 1'b1, 1'b1);
      repeat (23) press(1'b1, 1'b0);
      check("hour_23", 24'h230000, 1'b0, 1'b1);
      press(1'b1, 1'b0);
      check("hour_wrap", 24'h000000, 1'b0, 1'b1);

      // minute wrap from 00:59:37: no hour carry, seconds zeroed
      repeat (59) press(1'b0, 1'b1);
      repeat (37 * CR) step(1'b1, 1'b0, 1'b0, 1'b0);
      check("at_005937", 24'h005937, 1'b1, 1'b1);
      step(1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b1, 1'b0);
      check("min_wrap", 24'h000000, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b0, 1'b0);

      // minute edge on the tick cycle suppresses the tick
      repeat (2) step(1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b1, 1'b0);
      check("min_on_tick", 24'h000100, 1'b0, 1'b1);
      repeat (CR - 1) step(1'b1, 1'b0, 1'b0, 1'b0);
      check("no_early_tick", 24'h000100, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b0, 1'b0);
      check("tick_after_min", 24'h000101, 1'b1, 1'b1);

      // both buttons in one cycle
      step(1'b0, 1'b1, 1'b1, 1'b0);
      check("both_edges", 24'h010200, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b1);
      check("final_ack", 24'h010200, 1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", tot, bad);
      $finish;
   end

endmodule

// File: doc/time_counter.md
Name: time_counter

Overview:
- Time-of-day source for the character-LCD display path.
- Divides the system clock down to a 1 Hz tick and keeps HH:MM:SS as six BCD digits.
- Provides hour/minute set inputs.
- Raises a held refresh request that the downstream LCD driver acknowledges after redrawing the time field.
- Sits directly upstream of the LCD driver, in the same clock domain.

Parameters:
- CLOCK_RATE, 1000, clk cycles per second (the LCD path runs at 1 kHz). Legal range is ≥2. Prescaler width is $clog2(CLOCK_RATE).

Ports:
- clk  input  1  system clock, same clock as the LCD driver
- reset  input  1  asynchronous, active-low reset; asserted when 0
- run  input  1  1 = time advances; 0 = prescaler and digits frozen
- inc_hour  input  1  set-hour request, synchronous level; acts on 0->1 edge only
- inc_min  input  1  set-minute request, synchronous level; acts on 0->1 edge only
- refresh_ack  input  1  one-cycle pulse from LCD driver: time field redrawn
- digits  output  24  BCD {H10,H1,M10,M1,S10,S1}, 4 bits each, H10 in [23:20]
- sec_pulse  output  1  one-cycle pulse, registered, on each seconds advance
- refresh_req  output  1  high while a digit change is not yet acknowledged

Behaviour:
- Reset (reset=0, asynchronous):
  - digits=0, sec_pulse=0, refresh_req=1 (forces the initial draw of 00:00:00).
  - Prescaler=0; inc_hour/inc_min edge registers=0.
  - Reset mid-count discards all state.
- Prescaler:
  - When run=1, counts 0..CLOCK_RATE-1.
  - Reaching CLOCK_RATE-1 asserts internal tick; prescaler returns to 0 on the next edge.
  - When run=0, prescaler holds and no tick occurs.
- Tick latency: digits and sec_pulse update on the clock edge where prescaler==CLOCK_RATE-1 and run=1. With run held at 1, S1 first reaches 1 at the CLOCK_RATE-th rising edge after reset release.
- BCD cascade on tick:
  - S1 9->0 carries to S10; S10 5->0 carries to M1.
  - M1 9->0 carries to M10; M10 5->0 carries to hours.
  - Hours: {H10,H1}=23 -> 00; H1 9->0 with H10+1; otherwise H1+1.
  - 23:59:59 -> 00:00:00 in one tick.
  - Digits never leave legal ranges: H10 0-2, H1 0-9 (0-3 when H10=2), M10/S10 0-5, M1/S1 0-9.
- Edge detect: prev registers sample inc_hour/inc_min every cycle. Edge = input & ~prev. Holding an input high gives exactly one action.
- inc_hour edge:
  - Hours +1 with the same 23->00 wrap.
  - No carry to or from minutes.
  - Minutes and seconds unchanged.
- inc_min edge:
  - Minutes +1; 59->00 with no carry into hours.
  - Seconds forced to 00; prescaler forced to 0.
- Simultaneous events:
  - Any button edge in the same cycle as a tick suppresses that tick: no seconds advance, sec_pulse stays 0, prescaler still wraps to 0 (or is zeroed by inc_min).
  - Both button edges in one cycle: both apply (hours+1, minutes+1, seconds 00).
  - Button edges are honoured regardless of run.
- refresh_req:
  - Set on any edge where digits change (tick or button).
  - Cleared on refresh_ack=1 when no digit change occurs that cycle. Change and ack in the same cycle leave it set (change wins).
  - refresh_ack while refresh_req=0 has no effect.
  - No other handshake timing is required; digits stay valid and stable between changes.
- sec_pulse: high for exactly the one cycle after each non-suppressed tick; never high in consecutive cycles.

Test Plan:
- Reset, CLOCK_RATE=4, run=1 → digits=0x000000, refresh_req=1 during and after reset. First sec_pulse at 4th edge after release with digits=0x000001. 10th tick gives 0x000010.
- Hold run=0 for 20 cycles mid-count, then run=1 → digits and prescaler frozen; the next tick arrives exactly the remaining prescaler count after resume.
- 23 inc_hour pulses, 59 inc_min pulses, then 59 ticks → 0x235959. Next tick → 0x000000, sec_pulse=1, refresh_req=1. Further inc_hour from 23 → 00.
- inc_hour held high 10 cycles → single increment only. inc_min at 00:59:37 → 00:00:00 (no hour carry, seconds zeroed).
- inc_min edge coincident with prescaler==CLOCK_RATE-1 → seconds 00, no sec_pulse. Then the next tick comes CLOCK_RATE cycles later.
- refresh_ack with no change → refresh_req falls next edge. refresh_ack coincident with a tick → refresh_req stays 1. Assert reset=0 mid-count → digits=0 immediately (asynchronous), refresh_req=1.
